// File: rtl/lcb_uart_rx_framer.sv
// LCB receive front end: 8N1 oversampling deserialiser, sync-byte check and fixed-length frame assembly.
// Define LCB_RX_TIMEOUT_EN to abort partial frames after TIMEOUT_BITS idle bit-times.
`timescale 1ns/1ps
module lcb_uart_rx_framer #(
    parameter int         CLKS_PER_BIT    = 34,
    parameter int         BYTES_PER_FRAME = 8,
    parameter logic [7:0] SYNC_BYTE       = 8'h2A,
    parameter int         TIMEOUT_BITS    = 40
) (
    input  logic       clk80MHz,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rx_en,
    output logic [7:0] dataFromLCB,
    output logic       ValRX,
    output logic [3:0] byte_idx,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    IDX_LAST  = 4'(BYTES_PER_FRAME - 1);

    if (BYTES_PER_FRAME < 2 || BYTES_PER_FRAME > 16 || TIMEOUT_BITS < 1) begin : g_bad_param
        $error("lcb_uart_rx_framer: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          rx_meta_reg, rxs_reg, rxs_prev_reg;
    logic          start_edge, byte_ok, stop_err, timeout_hit;

    logic [7:0] data_reg;
    logic [3:0] byte_idx_reg;
    logic [1:0] err_code_reg;
    logic       val_rx_reg, frame_valid_reg, frame_err_reg;

    // Two-stage synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk80MHz or posedge reset) begin
        if (reset) begin
            rx_meta_reg  <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg  <= UART_RX;
            rxs_reg      <= rx_meta_reg;
            rxs_prev_reg <= rxs_reg;
        end
    end

    assign start_edge = rxs_prev_reg & ~rxs_reg;

    always_ff @(posedge clk80MHz or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        byte_ok    = 1'b0;
        stop_err   = 1'b0;
        if (!rx_en) begin
            state_next = S_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    cnt_next = '0;
                    if (start_edge) begin
                        state_next = S_START;
                        bit_next   = '0;
                    end
                end
                S_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_next   = '0;
                        state_next = rxs_reg ? S_IDLE : S_DATA;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_next   = '0;
                        shift_next = {rxs_reg, shift_reg[7:1]};
                        bit_next   = bit_reg + 3'd1;
                        if (bit_reg == 3'd7) state_next = S_STOP;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_next   = '0;
                        state_next = S_IDLE;
                        byte_ok    = rxs_reg;
                        stop_err   = ~rxs_reg;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

`ifdef LCB_RX_TIMEOUT_EN
    localparam int TLIM = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW   = $clog2(TLIM + 1);
    logic [TW-1:0] idle_cnt_reg;
    logic          idle_armed;

    // A start edge in the expiry cycle disarms the counter, so the new byte wins
    assign idle_armed  = rx_en && (state_reg == S_IDLE) && (byte_idx_reg != 4'd0) && !start_edge;
    assign timeout_hit = idle_armed && (idle_cnt_reg == TW'(TLIM - 1));

    always_ff @(posedge clk80MHz or posedge reset) begin
        if (reset)                         idle_cnt_reg <= '0;
        else if (!idle_armed || timeout_hit) idle_cnt_reg <= '0;
        else                               idle_cnt_reg <= idle_cnt_reg + TW'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Index advances the cycle after the strobe so byte_idx labels the byte being delivered
    always_ff @(posedge clk80MHz or posedge reset) begin
        if (reset) begin
            data_reg        <= '0;
            byte_idx_reg    <= '0;
            err_code_reg    <= 2'b00;
            val_rx_reg      <= 1'b0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            val_rx_reg      <= 1'b0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            if (!rx_en) begin
                byte_idx_reg <= '0;
            end else if (byte_ok) begin
                if (byte_idx_reg == 4'd0 && shift_reg != SYNC_BYTE) begin
                    frame_err_reg <= 1'b1;
                    err_code_reg  <= 2'b00;
                end else begin
                    data_reg        <= shift_reg;
                    val_rx_reg      <= 1'b1;
                    frame_valid_reg <= (byte_idx_reg == IDX_LAST);
                end
            end else if (stop_err) begin
                frame_err_reg <= 1'b1;
                err_code_reg  <= 2'b01;
                byte_idx_reg  <= '0;
            end else if (timeout_hit) begin
                frame_err_reg <= 1'b1;
                err_code_reg  <= 2'b10;
                byte_idx_reg  <= '0;
            end else if (val_rx_reg) begin
                byte_idx_reg <= (byte_idx_reg == IDX_LAST) ? 4'd0 : byte_idx_reg + 4'd1;
            end
        end
    end

    assign dataFromLCB = data_reg;
    assign ValRX       = val_rx_reg;
    assign byte_idx    = byte_idx_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_err   = frame_err_reg;
    assign err_code    = err_code_reg;
    assign busy        = (state_reg != S_IDLE) || (byte_idx_reg != 4'd0);
endmodule
